// File: rtl/sys_array_output_collector.sv
// Deskew stage at the south edge of the systolic mesh. Each column buffers its
// time-skewed results in its own FIFO; complete rows leave on one valid/ready port.
module sys_array_output_collector #(
    parameter int MESHCOLS = 2,
    parameter int TILECOLS = 1,
    parameter int BITWIDTH = 16,
    parameter int DEPTH    = 8,
    parameter int CNTWIDTH = 16
) (
    input  logic                                                 clock,
    input  logic                                                 reset,
    input  logic                                                 in_flush,
    input  logic signed [MESHCOLS-1:0][TILECOLS-1:0][BITWIDTH-1:0] in_c,
    input  logic        [MESHCOLS-1:0][TILECOLS-1:0]               in_c_valid,
    output logic signed [MESHCOLS-1:0][TILECOLS-1:0][BITWIDTH-1:0] out_row,
    output logic                                                 out_row_valid,
    input  logic                                                 out_row_ready,
    output logic [CNTWIDTH-1:0]                                  out_rows_emitted,
    output logic                                                 out_overflow,
    output logic                                                 out_busy
);

    localparam int NCOL = MESHCOLS * TILECOLS;
    localparam int AW   = $clog2(DEPTH);

    localparam logic [AW:0]         CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]         CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]       PTR_ONE  = AW'(1);
    localparam logic [CNTWIDTH-1:0] ROW_ONE  = CNTWIDTH'(1);

    logic [BITWIDTH-1:0] mem_q [NCOL][DEPTH];
    logic [AW-1:0]       wr_ptr_q [NCOL];
    logic [AW-1:0]       wr_ptr_d [NCOL];
    logic [AW-1:0]       rd_ptr_q [NCOL];
    logic [AW-1:0]       rd_ptr_d [NCOL];
    logic [AW:0]         cnt_q    [NCOL];
    logic [AW:0]         cnt_d    [NCOL];
    logic [CNTWIDTH-1:0] rows_q, rows_d;
    logic                overflow_q, overflow_d;

    logic [BITWIDTH-1:0] col_data [NCOL];
    logic [NCOL-1:0]     col_vld;
    logic [NCOL-1:0]     col_full;
    logic [NCOL-1:0]     col_nonempty;
    logic [NCOL-1:0]     push_en;
    logic                pop;

    // Flatten the [mesh][tile] port layout into column index c = l*TILECOLS + t.
    for (genvar l = 0; l < MESHCOLS; l++) begin : g_mesh
        for (genvar t = 0; t < TILECOLS; t++) begin : g_tile
            localparam int C = l * TILECOLS + t;
            assign col_vld[C]      = in_c_valid[l][t];
            assign col_data[C]     = in_c[l][t];
            assign col_full[C]     = (cnt_q[C] == CNT_FULL);
            assign col_nonempty[C] = (cnt_q[C] != '0);
            assign out_row[l][t]   = mem_q[C][rd_ptr_q[C]];
        end
    end

    assign out_row_valid    = &col_nonempty;
    assign out_busy         = |col_nonempty;
    assign out_rows_emitted = rows_q;
    assign out_overflow     = overflow_q;
    assign pop              = out_row_valid && out_row_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        rows_d     = rows_q;
        overflow_d = overflow_q;
        for (int c = 0; c < NCOL; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            cnt_d[c]    = cnt_q[c];
            push_en[c]  = 1'b0;
        end

        if (in_flush) begin
            for (int c = 0; c < NCOL; c++) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                cnt_d[c]    = '0;
            end
        end else begin
            if (pop) rows_d = rows_q + ROW_ONE;
            for (int c = 0; c < NCOL; c++) begin
                // A full column still accepts a sample when the same edge pops its head.
                push_en[c] = !reset && col_vld[c] && (!col_full[c] || pop);
                if (col_vld[c] && col_full[c] && !pop) overflow_d = 1'b1;
                if (push_en[c]) wr_ptr_d[c] = wr_ptr_q[c] + PTR_ONE;
                if (pop)        rd_ptr_d[c] = rd_ptr_q[c] + PTR_ONE;
                unique case ({push_en[c], pop})
                    2'b10:   cnt_d[c] = cnt_q[c] + CNT_ONE;
                    2'b01:   cnt_d[c] = cnt_q[c] - CNT_ONE;
                    default: cnt_d[c] = cnt_q[c];
                endcase
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rows_q     <= '0;
            overflow_q <= 1'b0;
            for (int c = 0; c < NCOL; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            rows_q     <= rows_d;
            overflow_q <= overflow_d;
            for (int c = 0; c < NCOL; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
        end
    end

    // NOTE: storage has no reset; the counts alone decide which entries are live.
    always_ff @(posedge clock) begin
        for (int c = 0; c < NCOL; c++) begin
            if (push_en[c]) mem_q[c][wr_ptr_q[c]] <= col_data[c];
        end
    end

endmodule
